alu_op_sequencer: RTL and testbench

- Issuing end of the ALU operand/command interface.
- Accepts signed 15-bit operation requests over a valid/ready handshake and encodes the operands into the ALU's 16-bit operand format.
- Drives the ALU command, waits out the ALU's negedge-capture/posedge-compute timing, and decodes the 15-bit result.
- MUL and DIV each issue two back-to-back ALU commands, and both halves come back in one response.
- Sits between the datapath controller and the ALU.

---
 rtl/alu_op_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues operand/command pairs to a one's-complement ALU,
// waits out its negedge-capture/posedge-compute latency and returns decoded
// two's-complement results. MUL and DIV use two back-to-back ALU commands.
module alu_op_sequencer #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [14:0] req_a,
    input  logic [14:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [14:0] rsp_lo,
    output logic [14:0] rsp_hi,
    output logic        rsp_err,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_command,
    input  logic [14:0] alu_res
);

    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;

    localparam logic [2:0] CMD_MUL_HI = 3'd3;
    localparam logic [2:0] CMD_MUL_LO = 3'd4;
    localparam logic [2:0] CMD_DIV_Q  = 3'd5;
    localparam logic [2:0] CMD_DIV_R  = 3'd6;

    localparam int unsigned CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    // ISSUE state already consumes one cycle, so the wait counter covers the rest
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 2);

    typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, RESP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [2:0]    op_q, op_d;
    logic [15:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]    alu_cmd_q, alu_cmd_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [14:0]   rsp_lo_q, rsp_lo_d, rsp_hi_q, rsp_hi_d;
    logic          req_err;
    logic [14:0]   res_dec;
    logic          two_step;

    // Two's complement -> ALU operand format (one's complement in [15:1], bit 0 clear)
    function automatic logic [15:0] enc(input logic [14:0] v);
        return {(v[14] ? (v - 15'd1) : v), 1'b0};
    endfunction

    // Request classification and result decoding
    always_comb begin
        req_err  = (req_op > OP_DIV) || ((req_op == OP_DIV) && (req_b == '0)) ||
                   (req_a == 15'h4000) || (req_b == 15'h4000);
        res_dec  = (op_q == OP_AND) ? alu_res : (alu_res[14] ? (alu_res + 15'd1) : alu_res);
        two_step = (op_q == OP_MUL) || (op_q == OP_DIV);
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        op_d        = op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cmd_d   = alu_cmd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_lo_d    = rsp_lo_q;
        rsp_hi_d    = rsp_hi_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    err_d   = req_err;
                    state_d = ISSUE1;
                    if (!req_err) begin
                        alu_a_d   = enc(req_a);
                        alu_b_d   = enc(req_b);
                        alu_cmd_d = (req_op == OP_MUL) ? CMD_MUL_HI :
                                    (req_op == OP_DIV) ? CMD_DIV_Q  : req_op;
                    end
                end
            end
            ISSUE1: begin
                if (err_q) begin
                    rsp_err_d   = 1'b1;
                    rsp_lo_d    = '0;
                    rsp_hi_d    = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (two_step) begin
                    if (op_q == OP_MUL) begin
                        rsp_hi_d  = res_dec;
                        alu_cmd_d = CMD_MUL_LO;
                    end else begin
                        rsp_lo_d  = res_dec;
                        alu_cmd_d = CMD_DIV_R;
                    end
                    state_d = ISSUE2;
                end else begin
                    rsp_lo_d    = res_dec;
                    rsp_hi_d    = '0;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            ISSUE2: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT2;
            end
            WAIT2: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (op_q == OP_MUL) rsp_lo_d = res_dec;
                    else                rsp_hi_d = res_dec;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            op_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cmd_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_lo_q    <= '0;
            rsp_hi_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            op_q        <= op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cmd_q   <= alu_cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_hi_q    <= rsp_hi_d;
        end
    end

    assign req_ready   = (state_q == IDLE) && !reset;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_lo      = rsp_lo_q;
    assign rsp_hi      = rsp_hi_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_command = alu_cmd_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: one's-complement ALU model attached to the
// DUT, directed cases plus randomized requests against an arithmetic model.
module tb_alu_op_sequencer;

    localparam int unsigned WAIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [14:0] req_a, req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [14:0] rsp_lo, rsp_hi;
    logic        rsp_err;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_command;
    logic [14:0] alu_res;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_command(alu_command),
        .alu_res(alu_res)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One's-complement helpers (the ALU's native number format)
    function automatic logic [14:0] enc1c(input int x);
        logic [14:0] m;
        if (x >= 0) return 15'(x);
        m = 15'(-x);
        return ~m;
    endfunction

    function automatic int dec1c(input logic [14:0] f);
        logic [14:0] nf;
        nf = ~f;
        if (f[14]) return -int'(nf);
        return int'(f);
    endfunction

    // ALU model: captures on negedge, produces result on the following posedge
    logic [15:0] cap_a, cap_b;
    logic [2:0]  cap_c;

    function automatic logic [14:0] alu_calc(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        int da, db, p;
        da = dec1c(a[15:1]);
        db = dec1c(b[15:1]);
        p  = da * db;
        case (c)
            3'd0: return enc1c(da + db);
            3'd1: return enc1c(da - db);
            3'd2: return a[15:1] & b[15:1];
            3'd3: return enc1c(p / 16384);
            3'd4: return enc1c(p % 16384);
            3'd5: return (db == 0) ? 15'd0 : enc1c(da / db);
            3'd6: return (db == 0) ? 15'd0 : enc1c(da % db);
            default: return 15'h2AAA;
        endcase
    endfunction

    always @(negedge clk) begin
        cap_a <= alu_a;
        cap_b <= alu_b;
        cap_c <= alu_command;
    end

    always @(posedge clk) alu_res <= alu_calc(cap_c, cap_a, cap_b);

    // Reference: what the consumer should see, from signed arithmetic
    task automatic ref_model(input int op, input int a, input int b,
                             output logic err, output logic [14:0] lo, output logic [14:0] hi);
        int p;
        err = (op > 4) || (op == 4 && b == 0) || (a == -16384) || (b == -16384);
        lo = '0;
        hi = '0;
        if (!err) begin
            case (op)
                0: lo = 15'(a + b);
                1: lo = 15'(a - b);
                2: lo = enc1c(a) & enc1c(b);
                3: begin p = a * b; hi = 15'(p / 16384); lo = 15'(p % 16384); end
                default: begin lo = 15'(a / b); hi = 15'(a % b); end
            endcase
        end
    endtask

    task automatic run_op(input int op, input int a, input int b, input int hold);
        logic        e_err;
        logic [14:0] e_lo, e_hi, lo_s, hi_s;
        logic [15:0] pa, pb;
        logic [2:0]  pc, c1, c2;
        int          e_lat, k;
        logic        seen;
        bit          two;
        ref_model(op, a, b, e_err, e_lo, e_hi);
        two   = (op == 3) || (op == 4);
        c1    = (op == 3) ? 3'd3 : (op == 4) ? 3'd5 : 3'(op);
        c2    = (op == 3) ? 3'd4 : 3'd6;
        e_lat = e_err ? 1 : (two ? 2 * WAIT : WAIT);

        @(negedge clk);
        check_eq("ready_idle", 32'(req_ready), 32'd1);
        pa = alu_a; pb = alu_b; pc = alu_command;
        req_valid = 1'b1; req_op = 3'(op); req_a = 15'(a); req_b = 15'(b);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 3'($urandom); req_a = 15'($urandom); req_b = 15'($urandom);
        if (e_err) begin
            check_eq("err_alu_a", 32'(alu_a), 32'(pa));
            check_eq("err_alu_b", 32'(alu_b), 32'(pb));
            check_eq("err_alu_cmd", 32'(alu_command), 32'(pc));
        end else begin
            check_eq("alu_a", 32'(alu_a), 32'({enc1c(a), 1'b0}));
            check_eq("alu_b", 32'(alu_b), 32'({enc1c(b), 1'b0}));
            check_eq("alu_cmd1", 32'(alu_command), 32'(c1));
        end

        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k == 1) check_eq("busy_ready", 32'(req_ready), 32'd0);
            if (!e_err && k < WAIT) check_eq("cmd_hold", 32'(alu_command), 32'(c1));
            if (!e_err && two && k == WAIT) check_eq("alu_cmd2", 32'(alu_command), 32'(c2));
            if (rsp_valid) seen = 1'b1;
        end
        check_eq("latency", 32'(k), 32'(e_lat));
        check_eq("rsp_err", 32'(rsp_err), 32'(e_err));
        check_eq("rsp_lo", 32'(rsp_lo), 32'(e_lo));
        check_eq("rsp_hi", 32'(rsp_hi), 32'(e_hi));
        lo_s = rsp_lo;
        hi_s = rsp_hi;

        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
            end
            check_eq("bp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_ready", 32'(req_ready), 32'd0);
            check_eq("bp_lo", 32'(rsp_lo), 32'(lo_s));
            check_eq("bp_hi", 32'(rsp_hi), 32'(hi_s));
            check_eq("bp_err", 32'(rsp_err), 32'(e_err));
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rel_valid", 32'(rsp_valid), 32'd0);
        check_eq("rel_err", 32'(rsp_err), 32'd0);
        check_eq("rel_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int op, a, b, cnt;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_alu_a", 32'(alu_a), 32'd0);
        check_eq("rst_alu_b", 32'(alu_b), 32'd0);
        check_eq("rst_alu_cmd", 32'(alu_command), 32'd0);
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_lo_hi", 32'({rsp_lo, rsp_hi, rsp_err}), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;

        run_op(0, 5, -3, 0);
        run_op(1, 2, 7, 0);
        run_op(2, 16'h00F0, 16'h0FF0, 0);
        run_op(3, 300, 200, 0);
        run_op(4, 100, 7, 0);
        run_op(4, 100, 0, 0);
        run_op(3, -16384, 5, 0);
        run_op(6, 1, 1, 0);
        run_op(4, -16383, 16383, 0);
        run_op(3, -300, 200, 5);
        run_op(0, 11, 22, 5);

        // Reset while the first MUL command is in flight
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd3; req_a = 15'd300; req_b = 15'd200;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_alu_a", 32'(alu_a), 32'd0);
        check_eq("mid_rst_alu_b", 32'(alu_b), 32'd0);
        check_eq("mid_rst_cmd", 32'(alu_command), 32'd0);
        check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        check_eq("mid_rst_no_rsp", 32'(cnt), 32'd0);

        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
            if (op == 2 || op == 4) begin
                a = int'($urandom_range(0, 32766)) - 16383;
                b = int'($urandom_range(0, 32766)) - 16383;
            end else begin
                a = int'($urandom_range(0, 16382)) - 8191;
                b = int'($urandom_range(0, 16382)) - 8191;
            end
            if ($urandom_range(0, 15) == 0) a = -16384;
            if ($urandom_range(0, 15) == 0) b = -16384;
            if (op == 4 && $urandom_range(0, 7) == 0) b = 0;
            run_op(op, a, b, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
